ipf_if_fifo: RTL and testbench

//  Parametrised elastic IPF->IF boundary replacing fixed stall/flush flop stages with a DEPTH-entry queue.

---
 rtl/ipf_if_fifo_if.sv | 27 ++
 rtl/ipf_if_fifo.sv | 123 ++++++++++++
 tb/tb_ipf_if_fifo.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ipf_if_fifo_if.sv
// Bundle of the IPF->IF queue handshake signals: push side, pop side, flush and status.
// master: IPF/IF side (drives flush, in_valid/in_data, out_ready; observes ready/valid/status).
// slave : the queue itself (ipf_if_fifo).
interface ipf_if_fifo_if #(
    parameter int DATA_W = 75,
    parameter int DEPTH  = 4
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [$clog2(DEPTH):0]   count;
    logic                     almost_full;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, almost_full
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, almost_full
    );
endinterface

// File: rtl/ipf_if_fifo.sv
// Purpose: elastic DEPTH-entry queue between IPF and IF carrying packed fetch bundles.
// Latency: 1 cycle push-to-head; 0 cycles when empty and IPF_IF_FIFO_BYPASS_EN is defined.
// Backpressure: in_ready drops when full, in flush or in reset; almost_full warns IPF early.
// Ports: clk, rst (async active-high); bus (ipf_if_fifo_if.slave):
//   flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data, count, almost_full.
// Optional macro: IPF_IF_FIFO_BYPASS_EN enables empty-queue pass-through.
module ipf_if_fifo #(
    parameter int DATA_W       = 75,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = 3
) (
    input  logic          clk,
    input  logic          rst,
    ipf_if_fifo_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Occupancy state is fully determined by count; decoded rather than stored.
    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_e;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    occ_e              occ;

    logic              byp_vld;
    logic              byp_take;
    logic              push;
    logic              pop;
    logic              wr_en;
    logic              rd_en;
    logic              in_ready_c;
    logic              out_valid_c;
    logic [DATA_W-1:0] out_data_c;

    always_comb begin
        occ = OCC_PARTIAL;
        if (count_q == '0) begin
            occ = OCC_EMPTY;
        end else if (count_q == CNT_W'(DEPTH)) begin
            occ = OCC_FULL;
        end
    end

`ifdef IPF_IF_FIFO_BYPASS_EN
    // Incoming bundle is visible at the head in the same cycle when nothing is queued.
    assign byp_vld = (occ == OCC_EMPTY) & bus.in_valid & ~bus.flush & ~rst;
`else
    assign byp_vld = 1'b0;
`endif

    always_comb begin
        // Full blocks pushes even if the head is popped this cycle.
        in_ready_c  = ~rst & ~bus.flush & (occ != OCC_FULL);
        out_valid_c = ~rst & ~bus.flush & ((occ != OCC_EMPTY) | byp_vld);

        out_data_c = '0;
        if (occ != OCC_EMPTY) begin
            out_data_c = mem_q[rd_ptr_q];
        end else if (byp_vld) begin
            out_data_c = bus.in_data;
        end

        push     = bus.in_valid & in_ready_c;
        pop      = out_valid_c & bus.out_ready;
        // A bypassed bundle consumed on the spot never touches storage.
        byp_take = byp_vld & bus.out_ready;
        wr_en    = push & ~byp_take;
        rd_en    = pop & (occ != OCC_EMPTY);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_c;
    assign bus.out_data    = out_data_c;
    assign bus.count       = count_q;
    assign bus.almost_full = ~rst & (count_q >= CNT_W'(AFULL_THRESH));
endmodule

// File: tb/tb_ipf_if_fifo.sv
module tb_ipf_if_fifo;
    localparam int DATA_W = 75;
    localparam int DEPTH  = 4;
    localparam int AFULL  = 3;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
`ifdef IPF_IF_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef logic [DATA_W-1:0] dat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ipf_if_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    ipf_if_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_THRESH(AFULL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: the scoreboard queue is the queue contents.
    dat_t sb[$];
    bit   pend;        // bundle accepted this cycle, enters the model at the next edge
    dat_t pend_dat;
    bit   pend_flush;  // flush this cycle, model empties at the next edge
    bit   byp_exp;     // this cycle's bundle is expected to pass straight through
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input dat_t act, input dat_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One stimulus cycle: commit last cycle's outcome to the model, then drive new inputs.
    task automatic cyc(input bit iv, input dat_t d, input bit ordy, input bit fl);
        @(posedge clk);
        if (pend_flush) sb.delete();
        else if (pend) sb.push_back(pend_dat);
        #1;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
        pend       = 1'b0;
        byp_exp    = 1'b0;
        pend_flush = fl;
        if (!fl && iv) begin
            if (BYP && sb.size() == 0 && ordy) byp_exp = 1'b1;
            else if (sb.size() < DEPTH) begin
                pend     = 1'b1;
                pend_dat = d;
            end else begin
                pend = 1'b0;
            end
            if (BYP && sb.size() == 0 && !ordy) byp_exp = 1'b1;
        end
    endtask

    // Monitor: compares DUT status against the model and pops on every head handshake.
    always @(negedge clk) begin
        int   sz;
        bit   exp_vld;
        bit   exp_rdy;
        dat_t head;
        if (rst) begin
            chk("rst_out_valid", dat_t'(bus.out_valid), '0);
            chk("rst_in_ready", dat_t'(bus.in_ready), '0);
            chk("rst_count", dat_t'(bus.count), '0);
            chk("rst_almost_full", dat_t'(bus.almost_full), '0);
            chk("rst_out_data", bus.out_data, '0);
        end else begin
            sz      = sb.size();
            exp_rdy = !bus.flush && (sz < DEPTH);
            exp_vld = !bus.flush && (sz != 0 || byp_exp);
            chk("count", dat_t'(bus.count), dat_t'(sz));
            chk("in_ready", dat_t'(bus.in_ready), dat_t'(exp_rdy));
            chk("out_valid", dat_t'(bus.out_valid), dat_t'(exp_vld));
            chk("almost_full", dat_t'(bus.almost_full), dat_t'(sz >= AFULL));
            if (exp_vld) begin
                head = (sz != 0) ? sb[0] : bus.in_data;
                chk("out_data", bus.out_data, head);
                if (bus.out_ready && sz != 0) void'(sb.pop_front());
            end else if (sz == 0) begin
                chk("out_data_empty", bus.out_data, '0);
            end
        end
    end

    // Asynchronous reset partway through a cycle; outputs must clear without an edge.
    task automatic mid_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_count", dat_t'(bus.count), '0);
        chk("async_out_valid", dat_t'(bus.out_valid), '0);
        chk("async_in_ready", dat_t'(bus.in_ready), '0);
        sb.delete();
        pend = 1'b0; pend_flush = 1'b0; byp_exp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pend = 1'b0; pend_flush = 1'b0; byp_exp = 1'b0;
        bus.flush = 1'b0; bus.in_valid = 1'b1; bus.in_data = dat_t'(12'hABC); bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b0;

        // Fill to full; the fifth push must be refused.
        for (int i = 1; i <= 5; i++) cyc(1'b1, dat_t'(i), 1'b0, 1'b0);
        // Full with simultaneous traffic: pop only, then push+pop.
        cyc(1'b1, dat_t'(5), 1'b1, 1'b0);
        cyc(1'b1, dat_t'(5), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        // Streaming across the pointer wrap.
        for (int i = 0; i < 10; i++) cyc(1'b1, dat_t'(16 + i), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        // Flush with three queued and a competing push/pop.
        for (int i = 0; i < 3; i++) cyc(1'b1, dat_t'(32 + i), 1'b0, 1'b0);
        cyc(1'b1, dat_t'(8'hFF), 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        // Empty queue with a ready consumer.
        cyc(1'b1, dat_t'(12'hABC), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            dat_t d;
            d = {$urandom, $urandom, $urandom};
            cyc(($urandom % 4) != 0, d, ($urandom % 3) != 0, ($urandom % 25) == 0);
        end
        mid_reset();
        for (int i = 0; i < 300; i++) begin
            dat_t d;
            d = {$urandom, $urandom, $urandom};
            cyc(($urandom % 2) != 0, d, ($urandom % 2) != 0, ($urandom % 30) == 0);
        end
        for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
